layer1_idb1_weight_feeder: RTL and testbench
============================================

Name: layer1_idb1_weight_feeder

Overview:
- Weight-streaming transmitter for the layer1 identity bottleneck block. Drives the three weight streams (valid + data) that the 1x1/3x3/1x1 conv stages consume.
- Reads weights sequentially from a synchronous weight memory and emits conv1, then conv2, then conv3 weights, one word per cycle.
- Sits between the weight store and the bottleneck block. Started by the layer controller; reports completion with `done`.

Parameters:
- DATA_WIDTH, 32, weight word width (FP32).
- ADDR_WIDTH, 17, weight memory address width.
- BASE_ADDR, 0, address of the first conv1 weight.
- N_W1, 16384, conv1 weight count (256 in x 64 out x 1x1).
- N_W2, 36864, conv2 weight count (64 x 64 x 3x3).
- N_W3, 16384, conv3 weight count (64 x 256 x 1x1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a full weight load when idle.
- pause  in  1  when high, no new memory read is issued.
- mem_rd_en  out  1  weight memory read strobe.
- mem_addr  out  ADDR_WIDTH  weight memory read address.
- mem_rd_data  in  DATA_WIDTH  memory data, valid 1 cycle after mem_rd_en.
- valid_weight_out1  out  1  conv1 weight strobe.
- weight_out1  out  DATA_WIDTH  conv1 weight.
- valid_weight_out2  out  1  conv2 weight strobe.
- weight_out2  out  DATA_WIDTH  conv2 weight.
- valid_weight_out3  out  1  conv3 weight strobe.
- weight_out3  out  DATA_WIDTH  conv3 weight.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last conv3 weight is emitted.

Behaviour:
- Reset state: FSM in IDLE. All outputs 0, mem_addr 0, all counters 0. Reset takes effect immediately and asynchronously, including mid-load; the in-flight read is discarded.
- FSM states: IDLE -> RUN1 -> RUN2 -> RUN3 -> DRAIN -> IDLE.
  - IDLE -> RUN1 on start. mem_addr is loaded with BASE_ADDR and the per-stream counter is cleared.
  - RUNk issues one read per cycle while pause=0. mem_addr increments by 1 per issued read, contiguously across all three segments.
  - RUNk -> RUN(k+1) in the cycle the N_Wk-th read of stream k is issued. RUN3 -> DRAIN on the N_W3-th read.
- Pipeline, per read issued in cycle t:
  - t+1: mem_rd_data is returned and captured with a 2-bit stream tag.
  - t+2: weight_outk <= captured data and valid_weight_outk = 1, for the tagged stream k only.
  - Output latency from read issue is 2 cycles.
- Stream hygiene:
  - Exactly one valid_weight_outk may be high in any cycle.
  - weight_outk holds its last value while its valid is low.
  - Streams never interleave: stream k+1's first valid follows stream k's last valid, with no gap unless pause intervenes.
- DRAIN waits until both pipeline stages are empty. It then pulses done for 1 cycle, deasserts busy in that same cycle and returns to IDLE.
- pause: suppresses mem_rd_en only. Reads already in flight still emerge, because the downstream blocks have no backpressure. Pause in IDLE or DRAIN has no effect.
- start while busy is ignored. start in the same cycle as done is ignored; it is accepted in the next cycle.
- Counters: each is sized by $clog2 of its N_Wk + 1. The address does not wrap within a load; BASE_ADDR + N_W1 + N_W2 + N_W3 must fit in ADDR_WIDTH, checked by a parameter assertion.
- Total valids per load: exactly N_W1 on stream 1, N_W2 on stream 2 and N_W3 on stream 3.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, RUN1, RUN2, RUN3, DRAIN);
  - stream tag constants (TAG_NONE, TAG_W1, TAG_W2, TAG_W3);
  - the default weight counts for the layer1 bottleneck.
- One sub-module, weight_rd_pipe: a 2-stage tagged read-return pipeline that turns (rd_en, tag, mem_rd_data) into per-stream valid/data.
- FSM and address generation stay in the top module.

Test Plan (N_W1=4, N_W2=9, N_W3=4, BASE_ADDR=8; memory returns data = address):
- Single load, no pause:
  - start at cycle 0 -> mem_addr runs 8..24 on consecutive cycles.
  - valid_weight_out1 carries 8..11, valid_weight_out2 carries 12..20, valid_weight_out3 carries 21..24, back-to-back with no gaps.
  - done pulses once, 2 cycles after the last conv3 valid; busy is high throughout.
- Pause mid-conv2: pause held for 3 cycles after the address-14 read -> stream 2 shows a 3-cycle gap in its valids. Data sequence is unchanged, total 9 words; no valid on streams 1 or 3 during the gap.
- Boundary pause: pause asserted in the cycle the last conv1 read is issued -> the last conv1 word (11) still emerges 2 cycles later, and conv2 starts only after pause drops.
- Start while busy: a second start pulse during RUN2 -> ignored; exactly 17 valids in total and a single done.
- Reset mid-op: reset low during RUN2 -> all valids, mem_rd_en, busy and done are 0 immediately. After release the block is in IDLE, and a new start replays from address 8.
- Back-to-back loads: start in the cycle after done -> second load is identical to the first, with correct per-stream counts.

Source files
------------

// File: rtl/layer1_idb1_weight_feeder_pkg.sv
// Shared types and default sizes for the layer1 identity-bottleneck weight feeder.
// The defaults are the real layer1 weight counts; test builds override them.
package layer1_idb1_weight_feeder_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN1  = 3'd1,
        S_RUN2  = 3'd2,
        S_RUN3  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    // Marks which conv stream an in-flight read belongs to.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_W1   = 2'd1,
        TAG_W2   = 2'd2,
        TAG_W3   = 2'd3
    } tag_e;

    localparam int unsigned DEF_N_W1 = 16384;  // 256 in x 64 out x 1x1
    localparam int unsigned DEF_N_W2 = 36864;  // 64 x 64 x 3x3
    localparam int unsigned DEF_N_W3 = 16384;  // 64 x 256 x 1x1

endpackage

// File: rtl/layer1_idb1_weight_feeder_if.sv
// Control, weight-memory read and weight-stream signals of the weight feeder.
// The feeder uses master; the controller, memory and conv stages use slave.
interface layer1_idb1_weight_feeder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17
);
    logic                  start;
    logic                  pause;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  valid_weight_out1;
    logic [DATA_WIDTH-1:0] weight_out1;
    logic                  valid_weight_out2;
    logic [DATA_WIDTH-1:0] weight_out2;
    logic                  valid_weight_out3;
    logic [DATA_WIDTH-1:0] weight_out3;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, pause, mem_rd_data,
        output mem_rd_en, mem_addr,
        output valid_weight_out1, weight_out1,
        output valid_weight_out2, weight_out2,
        output valid_weight_out3, weight_out3,
        output busy, done
    );

    modport slave (
        output start, pause, mem_rd_data,
        input  mem_rd_en, mem_addr,
        input  valid_weight_out1, weight_out1,
        input  valid_weight_out2, weight_out2,
        input  valid_weight_out3, weight_out3,
        input  busy, done
    );
endinterface

// File: rtl/layer1_idb1_weight_feeder_weight_rd_pipe.sv
// Two-stage tagged read-return pipeline: the tag follows the read for one cycle,
// then the returned word lands on the tagged stream's output register.
module layer1_idb1_weight_feeder_weight_rd_pipe
    import layer1_idb1_weight_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_en,
    input  tag_e                  rd_tag,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  valid_out1,
    output logic [DATA_WIDTH-1:0] data_out1,
    output logic                  valid_out2,
    output logic [DATA_WIDTH-1:0] data_out2,
    output logic                  valid_out3,
    output logic [DATA_WIDTH-1:0] data_out3,
    output logic                  pipe_empty
);
    tag_e                  tag_q, tag_d;
    logic                  valid1_q, valid1_d, valid2_q, valid2_d, valid3_q, valid3_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d, data2_q, data2_d, data3_q, data3_d;

    always_comb begin
        tag_d    = rd_en ? rd_tag : TAG_NONE;
        valid1_d = (tag_q == TAG_W1);
        valid2_d = (tag_q == TAG_W2);
        valid3_d = (tag_q == TAG_W3);
        // Each stream's data register only loads for its own words, so it holds otherwise.
        data1_d  = valid1_d ? mem_rd_data : data1_q;
        data2_d  = valid2_d ? mem_rd_data : data2_q;
        data3_d  = valid3_d ? mem_rd_data : data3_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q    <= TAG_NONE;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            valid3_q <= 1'b0;
            data1_q  <= '0;
            data2_q  <= '0;
            data3_q  <= '0;
        end else begin
            tag_q    <= tag_d;
            valid1_q <= valid1_d;
            valid2_q <= valid2_d;
            valid3_q <= valid3_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            data3_q  <= data3_d;
        end
    end

    assign valid_out1 = valid1_q;
    assign valid_out2 = valid2_q;
    assign valid_out3 = valid3_q;
    assign data_out1  = data1_q;
    assign data_out2  = data2_q;
    assign data_out3  = data3_q;
    assign pipe_empty = (tag_q == TAG_NONE) && !(valid1_q || valid2_q || valid3_q);

endmodule

// File: rtl/layer1_idb1_weight_feeder.sv
// Streams conv1, conv2 then conv3 weights from a synchronous weight memory,
// one read per cycle over a contiguous address range, then drains and pulses done.
module layer1_idb1_weight_feeder
    import layer1_idb1_weight_feeder_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 17,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned N_W1       = DEF_N_W1,
    parameter int unsigned N_W2       = DEF_N_W2,
    parameter int unsigned N_W3       = DEF_N_W3
) (
    input logic                     clk,
    input logic                     reset,
    layer1_idb1_weight_feeder_if.master bus
);
    localparam int C1W = $clog2(N_W1 + 1);
    localparam int C2W = $clog2(N_W2 + 1);
    localparam int C3W = $clog2(N_W3 + 1);
    localparam logic [C1W-1:0] LAST1 = C1W'(N_W1 - 1);
    localparam logic [C2W-1:0] LAST2 = C2W'(N_W2 - 1);
    localparam logic [C3W-1:0] LAST3 = C3W'(N_W3 - 1);
    localparam logic [63:0] ADDR_END  = 64'(BASE_ADDR) + 64'(N_W1) + 64'(N_W2) + 64'(N_W3);
    localparam logic [63:0] ADDR_SPAN = 64'd1 << ADDR_WIDTH;

    // The address counter never wraps within a load.
    if (ADDR_END >= ADDR_SPAN) begin : g_addr_range_check
        $error("BASE_ADDR + N_W1 + N_W2 + N_W3 does not fit in ADDR_WIDTH");
    end

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C1W-1:0]        cnt1_q, cnt1_d;
    logic [C2W-1:0]        cnt2_q, cnt2_d;
    logic [C3W-1:0]        cnt3_q, cnt3_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rd_en;
    tag_e                  rd_tag;
    logic                  pipe_empty;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        cnt3_d  = cnt3_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rd_en   = 1'b0;
        rd_tag  = TAG_NONE;
        case (state_q)
            // A start coinciding with the done pulse is dropped.
            S_IDLE: if (bus.start && !done_q) begin
                state_d = S_RUN1;
                addr_d  = ADDR_WIDTH'(BASE_ADDR);
                cnt1_d  = '0;
                cnt2_d  = '0;
                cnt3_d  = '0;
                busy_d  = 1'b1;
            end
            S_RUN1: if (!bus.pause) begin
                rd_en  = 1'b1;
                rd_tag = TAG_W1;
                addr_d = addr_q + ADDR_WIDTH'(1);
                cnt1_d = cnt1_q + C1W'(1);
                if (cnt1_q == LAST1) state_d = S_RUN2;
            end
            S_RUN2: if (!bus.pause) begin
                rd_en  = 1'b1;
                rd_tag = TAG_W2;
                addr_d = addr_q + ADDR_WIDTH'(1);
                cnt2_d = cnt2_q + C2W'(1);
                if (cnt2_q == LAST2) state_d = S_RUN3;
            end
            S_RUN3: if (!bus.pause) begin
                rd_en  = 1'b1;
                rd_tag = TAG_W3;
                addr_d = addr_q + ADDR_WIDTH'(1);
                cnt3_d = cnt3_q + C3W'(1);
                if (cnt3_q == LAST3) state_d = S_DRAIN;
            end
            S_DRAIN: if (pipe_empty) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            cnt3_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            cnt3_q  <= cnt3_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.mem_rd_en = rd_en;
    assign bus.mem_addr  = addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    layer1_idb1_weight_feeder_weight_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_pipe (
        .clk         (clk),
        .reset       (reset),
        .rd_en       (rd_en),
        .rd_tag      (rd_tag),
        .mem_rd_data (bus.mem_rd_data),
        .valid_out1  (bus.valid_weight_out1),
        .data_out1   (bus.weight_out1),
        .valid_out2  (bus.valid_weight_out2),
        .data_out2   (bus.weight_out2),
        .valid_out3  (bus.valid_weight_out3),
        .data_out3   (bus.weight_out3),
        .pipe_empty  (pipe_empty)
    );

endmodule

// File: tb/tb_layer1_idb1_weight_feeder.sv
// Bench for the layer1 weight feeder with N_W1=4, N_W2=9, N_W3=4, BASE_ADDR=8;
// the memory model returns data equal to the read address.
module tb_layer1_idb1_weight_feeder;
    localparam int DW = 32;
    localparam int AW = 17;
    localparam int NCYC = 23;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    layer1_idb1_weight_feeder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    layer1_idb1_weight_feeder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (8),
        .N_W1       (4),
        .N_W2       (9),
        .N_W3       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= DW'(bus.mem_addr);

    typedef struct {
        logic          start;
        logic          pause;
        logic          rd_en;
        logic [AW-1:0] addr;
        logic [2:0]    v;     // {v3, v2, v1}
        logic [DW-1:0] w1, w2, w3;
        logic          busy;
        logic          done;
    } vec_t;

    vec_t tbl [NCYC];
    int n_tests = 0;
    int n_fail  = 0;

    int q1[$], q2[$], q3[$];
    int f1, l1, f2, l2, f3, l3;
    int done_n, multi_n;
    int done_c[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs ncyc cycles from IDLE, pulsing start at s_a/s_b and holding pause over [p_from, p_to].
    task automatic run_seq(input int ncyc, input int s_a, input int s_b,
                           input int p_from, input int p_to);
        q1.delete(); q2.delete(); q3.delete(); done_c.delete();
        f1 = -1; l1 = -1; f2 = -1; l2 = -1; f3 = -1; l3 = -1;
        done_n = 0; multi_n = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            bus.start = (c == s_a) || (c == s_b);
            bus.pause = (c >= p_from) && (c <= p_to);
            #1;
            if (bus.valid_weight_out1) begin q1.push_back(int'(bus.weight_out1)); if (f1 < 0) f1 = c; l1 = c; end
            if (bus.valid_weight_out2) begin q2.push_back(int'(bus.weight_out2)); if (f2 < 0) f2 = c; l2 = c; end
            if (bus.valid_weight_out3) begin q3.push_back(int'(bus.weight_out3)); if (f3 < 0) f3 = c; l3 = c; end
            if (int'(bus.valid_weight_out1) + int'(bus.valid_weight_out2) + int'(bus.valid_weight_out3) > 1)
                multi_n++;
            if (bus.done) begin done_n++; done_c.push_back(c); end
        end
        bus.start = 1'b0;
        bus.pause = 1'b0;
    endtask

    task automatic chk_stream(input string name, input int q[$], input int first_val,
                              input int seg, input int n);
        chk({name, "_count"}, q.size(), n);
        for (int i = 0; i < q.size() && i < n; i++)
            chk($sformatf("%s_word%0d", name, i), q[i], first_val + (i % seg));
    endtask

    function automatic int done_at(input int k);
        return (done_c.size() > k) ? done_c[k] : -1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < NCYC; c++) begin
            tbl[c].start = (c == 0);
            tbl[c].pause = 1'b0;
            tbl[c].rd_en = (c >= 1 && c <= 17);
            tbl[c].addr  = (c == 0) ? AW'(0) : (c <= 17) ? AW'(c + 7) : AW'(25);
            tbl[c].v     = {(c >= 16 && c <= 19), (c >= 7 && c <= 15), (c >= 3 && c <= 6)};
            tbl[c].w1    = (c < 3)  ? DW'(0) : (c <= 6)  ? DW'(c + 5) : DW'(11);
            tbl[c].w2    = (c < 7)  ? DW'(0) : (c <= 15) ? DW'(c + 5) : DW'(20);
            tbl[c].w3    = (c < 16) ? DW'(0) : (c <= 19) ? DW'(c + 5) : DW'(24);
            tbl[c].busy  = (c >= 1 && c <= 20);
            tbl[c].done  = (c == 21);
        end

        reset = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rd_en", int'(bus.mem_rd_en), 0);
        chk("rst_addr",  int'(bus.mem_addr), 0);
        chk("rst_valids", int'({bus.valid_weight_out3, bus.valid_weight_out2, bus.valid_weight_out1}), 0);
        chk("rst_w1",    int'(bus.weight_out1), 0);
        chk("rst_busy",  int'(bus.busy), 0);
        chk("rst_done",  int'(bus.done), 0);
        @(negedge clk);
        reset = 1'b1;

        // Single load, cycle by cycle
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            bus.start = tbl[c].start;
            bus.pause = tbl[c].pause;
            #1;
            chk($sformatf("tbl%0d_rd_en", c), int'(bus.mem_rd_en), int'(tbl[c].rd_en));
            chk($sformatf("tbl%0d_addr", c),  int'(bus.mem_addr), int'(tbl[c].addr));
            chk($sformatf("tbl%0d_valids", c),
                int'({bus.valid_weight_out3, bus.valid_weight_out2, bus.valid_weight_out1}), int'(tbl[c].v));
            chk($sformatf("tbl%0d_w1", c), int'(bus.weight_out1), int'(tbl[c].w1));
            chk($sformatf("tbl%0d_w2", c), int'(bus.weight_out2), int'(tbl[c].w2));
            chk($sformatf("tbl%0d_w3", c), int'(bus.weight_out3), int'(tbl[c].w3));
            chk($sformatf("tbl%0d_busy", c), int'(bus.busy), int'(tbl[c].busy));
            chk($sformatf("tbl%0d_done", c), int'(bus.done), int'(tbl[c].done));
        end
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

        // Pause for 3 cycles right after the address-14 read (cycle 7)
        run_seq(40, 0, -1, 8, 10);
        chk_stream("pz_s1", q1, 8, 4, 4);
        chk_stream("pz_s2", q2, 12, 9, 9);
        chk_stream("pz_s3", q3, 21, 4, 4);
        chk("pz_s2_first", f2, 7);
        chk("pz_s2_span", l2 - f2, 11);
        chk("pz_s1_before_s2", int'(l1 < f2), 1);
        chk("pz_s3_after_s2", int'(f3 > l2), 1);
        chk("pz_onehot", multi_n, 0);
        chk("pz_done_n", done_n, 1);
        chk("pz_done_c", done_at(0), 24);

        // Pause right after the last conv1 read issues (cycle 4)
        run_seq(40, 0, -1, 5, 7);
        chk_stream("bp_s1", q1, 8, 4, 4);
        chk("bp_s1_last", l1, 6);
        chk("bp_s2_first", f2, 10);
        chk_stream("bp_s2", q2, 12, 9, 9);
        chk("bp_done_c", done_at(0), 24);

        // Second start during RUN2 is ignored
        run_seq(50, 0, 8, -1, -2);
        chk("sb_n1", q1.size(), 4);
        chk("sb_n2", q2.size(), 9);
        chk("sb_n3", q3.size(), 4);
        chk("sb_done_n", done_n, 1);
        chk("sb_done_c", done_at(0), 21);

        // Start in the same cycle as done is ignored
        run_seq(50, 0, 21, -1, -2);
        chk("sd_n1", q1.size(), 4);
        chk("sd_n2", q2.size(), 9);
        chk("sd_n3", q3.size(), 4);
        chk("sd_done_n", done_n, 1);

        // Back-to-back: start the cycle after done
        run_seq(60, 0, 22, -1, -2);
        chk_stream("bb_s1", q1, 8, 4, 8);
        chk_stream("bb_s2", q2, 12, 9, 18);
        chk_stream("bb_s3", q3, 21, 4, 8);
        chk("bb_onehot", multi_n, 0);
        chk("bb_done_n", done_n, 2);
        chk("bb_done_c0", done_at(0), 21);
        chk("bb_done_c1", done_at(1), 43);

        // Asynchronous reset during RUN2
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.start = (c == 0);
            #1;
        end
        chk("mr_pre_v2", int'(bus.valid_weight_out2), 1);
        chk("mr_pre_w2", int'(bus.weight_out2), 14);
        reset = 1'b0;
        #1;
        chk("mr_rd_en", int'(bus.mem_rd_en), 0);
        chk("mr_valids", int'({bus.valid_weight_out3, bus.valid_weight_out2, bus.valid_weight_out1}), 0);
        chk("mr_busy", int'(bus.busy), 0);
        chk("mr_done", int'(bus.done), 0);
        chk("mr_addr", int'(bus.mem_addr), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("mr_idle_busy", int'(bus.busy), 0);
        run_seq(30, 0, -1, -1, -2);
        chk_stream("mr_s1", q1, 8, 4, 4);
        chk_stream("mr_s2", q2, 12, 9, 9);
        chk_stream("mr_s3", q3, 21, 4, 4);
        chk("mr_done_c", done_at(0), 21);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
